// File: rtl/grid_frame_writer_pkg.sv
// Shared constants, types and index helpers for the 64x48 2-bit colour grid.
// The same values are used by the VGA scan-out block.
package grid_frame_writer_pkg;

    localparam int GRID_W      = 64;
    localparam int GRID_H      = 48;
    localparam int CELL_BITS   = 2;
    localparam int GRID_CELLS  = GRID_W * GRID_H;     // 3072
    localparam int GRID_BITS   = GRID_CELLS * CELL_BITS; // 6144
    localparam int COORD_BITS  = 6;
    localparam int IDX_BITS    = 12;                  // cell index 0..4095
    localparam int OFF_BITS    = 13;                  // bit offset 0..8190

    localparam logic [CELL_BITS-1:0] COLOR_BLACK = 2'd0;
    localparam logic [CELL_BITS-1:0] COLOR_RED   = 2'd1;
    localparam logic [CELL_BITS-1:0] COLOR_GREEN = 2'd2;
    localparam logic [CELL_BITS-1:0] COLOR_BLUE  = 2'd3;

    typedef logic [IDX_BITS-1:0] idx_t;
    typedef logic [OFF_BITS-1:0] off_t;

    typedef enum logic [1:0] {
        IDLE        = 2'd0,
        CLEAR       = 2'd1,
        COMMIT_WAIT = 2'd2
    } state_e;

    // Row-major cell index; 12 bits hold every 6-bit x/y pair without wrap.
    function automatic idx_t cell_index(input logic [COORD_BITS-1:0] x,
                                        input logic [COORD_BITS-1:0] y);
        return idx_t'(y) * idx_t'(GRID_W) + idx_t'(x);
    endfunction

    // Position of a cell's lowest colour bit inside the flat grid vector.
    function automatic off_t cell_offset(input idx_t idx);
        return off_t'(idx) * off_t'(CELL_BITS);
    endfunction

endpackage

// File: rtl/grid_frame_writer_if.sv
// Game-logic side of the grid writer: single-cell write handshake plus the
// clear and commit control pulses.
interface grid_wr_if;
    import grid_frame_writer_pkg::*;

    logic                  wr_valid;
    logic                  wr_ready;
    logic [COORD_BITS-1:0] wr_x;
    logic [COORD_BITS-1:0] wr_y;
    logic [CELL_BITS-1:0]  wr_color;
    logic                  clr_start;
    logic [CELL_BITS-1:0]  clr_color;
    logic                  commit;

    modport master (
        output wr_valid, wr_x, wr_y, wr_color, clr_start, clr_color, commit,
        input  wr_ready
    );

    modport slave (
        input  wr_valid, wr_x, wr_y, wr_color, clr_start, clr_color, commit,
        output wr_ready
    );

endinterface

// File: rtl/grid_frame_writer.sv
// Grid frame writer: accepts cell writes and full-grid fills into a working
// grid, and publishes the working grid to grid_flat only during vblank so
// scan-out never sees a half-updated frame.
module grid_frame_writer
    import grid_frame_writer_pkg::*;
(
    input  logic                 clk,
    input  logic                 rst,
    grid_wr_if.slave             wr,
    input  logic                 vblank,
    output logic                 busy,
    output logic                 commit_done,
    output logic                 err_oob,
    output logic [GRID_BITS-1:0] grid_flat
);

    state_e                 state_q, state_d;
    idx_t                   cnt_q, cnt_d;
    logic [CELL_BITS-1:0]   fill_q, fill_d;
    logic                   pend_q, pend_d;
    logic                   err_q, err_d;
    logic                   done_q, done_d;
    logic [GRID_BITS-1:0]   work_q, work_d;
    logic [GRID_BITS-1:0]   flat_q, flat_d;

    off_t                   wr_off;
    off_t                   clr_off;
    logic                   wr_in_range;
    logic                   clr_last;

    assign wr_off      = cell_offset(cell_index(wr.wr_x, wr.wr_y));
    assign clr_off     = cell_offset(cnt_q);
    assign wr_in_range = 32'(wr.wr_y) < GRID_H;
    assign clr_last    = cnt_q == idx_t'(GRID_CELLS - 1);

    // Next-state, grid updates and handshake for the IDLE/CLEAR/COMMIT_WAIT FSM.
    always_comb begin
        // NOTE: every signal gets its hold/idle value first, so no path through
        // the case statement can leave one unassigned and infer a latch.
        state_d     = state_q;
        cnt_d       = cnt_q;
        fill_d      = fill_q;
        pend_d      = pend_q;
        err_d       = 1'b0;
        done_d      = 1'b0;
        work_d      = work_q;
        flat_d      = flat_q;
        wr.wr_ready = 1'b0;

        case (state_q)
            IDLE: begin
                // Control pulses take the cycle, so no write can collide with them.
                wr.wr_ready = ~wr.clr_start & ~wr.commit;
                if (wr.clr_start) begin
                    state_d = CLEAR;
                    cnt_d   = '0;
                    fill_d  = wr.clr_color;
                    pend_d  = 1'b0;
                end else if (wr.commit) begin
                    state_d = COMMIT_WAIT;
                end else if (wr.wr_valid) begin
                    if (wr_in_range) begin
                        work_d[wr_off +: CELL_BITS] = wr.wr_color;
                    end else begin
                        err_d = 1'b1;
                    end
                end
            end

            CLEAR: begin
                work_d[clr_off +: CELL_BITS] = fill_q;
                if (wr.commit) begin
                    pend_d = 1'b1;
                end
                if (clr_last) begin
                    cnt_d  = '0;
                    pend_d = 1'b0;
                    // A commit arriving on the final cell still counts as seen.
                    state_d = (pend_q | wr.commit) ? COMMIT_WAIT : IDLE;
                end else begin
                    cnt_d = cnt_q + idx_t'(1);
                end
            end

            COMMIT_WAIT: begin
                if (vblank) begin
                    flat_d  = work_q;
                    done_d  = 1'b1;
                    state_d = IDLE;
                end
            end

            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State and grid registers; reset aborts any clear or pending publish.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            // NOTE: the grids are flop arrays rather than RAM and must come up
            // all black, so they are reset like any other state.
            state_q <= IDLE;
            cnt_q   <= '0;
            fill_q  <= COLOR_BLACK;
            pend_q  <= 1'b0;
            err_q   <= 1'b0;
            done_q  <= 1'b0;
            work_q  <= '0;
            flat_q  <= '0;
        end else begin
            // NOTE: non-blocking assignments keep every register sampling the
            // pre-edge values, independent of statement order.
            state_q <= state_d;
            cnt_q   <= cnt_d;
            fill_q  <= fill_d;
            pend_q  <= pend_d;
            err_q   <= err_d;
            done_q  <= done_d;
            work_q  <= work_d;
            flat_q  <= flat_d;
        end
    end

    assign busy        = (state_q == CLEAR) || (state_q == COMMIT_WAIT);
    assign commit_done = done_q;
    assign err_oob     = err_q;
    assign grid_flat   = flat_q;

endmodule

// File: tb/tb_grid_frame_writer.sv
// Directed testbench for grid_frame_writer: writes, out-of-range writes,
// fills, commits inside and outside CLEAR, and asynchronous reset aborts.
module tb_grid_frame_writer;
    import grid_frame_writer_pkg::*;

    logic                 clk;
    logic                 rst;
    logic                 vblank;
    logic                 busy;
    logic                 commit_done;
    logic                 err_oob;
    logic [GRID_BITS-1:0] grid_flat;
    logic [GRID_BITS-1:0] exp_g;

    int total;
    int bad;
    int cnt_a;
    int cnt_b;

    grid_wr_if wif ();

    grid_frame_writer dut (
        .clk         (clk),
        .rst         (rst),
        .wr          (wif),
        .vblank      (vblank),
        .busy        (busy),
        .commit_done (commit_done),
        .err_oob     (err_oob),
        .grid_flat   (grid_flat)
    );

    // 50 MHz clock.
    initial clk = 1'b0;
    always #10 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic check_grid(input string tag, input logic [GRID_BITS-1:0] exp);
        int diff;
        int first;
        diff  = 0;
        first = -1;
        for (int c = 0; c < GRID_CELLS; c++) begin
            if (grid_flat[c*CELL_BITS +: CELL_BITS] !== exp[c*CELL_BITS +: CELL_BITS]) begin
                diff++;
                if (first < 0) first = c;
            end
        end
        total++;
        assert (grid_flat === exp) else begin
            bad++;
            if (first < 0) first = 0;
            $error("FAIL %s differing_cells=%0d first_cell=%0d observed=%0b expected=%0b",
                   tag, diff, first, grid_flat[first*CELL_BITS +: CELL_BITS],
                   exp[first*CELL_BITS +: CELL_BITS]);
        end
    endtask

    task automatic do_write(input logic [5:0] x, input logic [5:0] y, input logic [1:0] c);
        wif.wr_valid = 1'b1;
        wif.wr_x     = x;
        wif.wr_y     = y;
        wif.wr_color = c;
        tick();
        wif.wr_valid = 1'b0;
    endtask

    // Commit from IDLE with vblank already high: copy lands one edge later.
    task automatic publish(input string tag, input logic [GRID_BITS-1:0] exp);
        vblank     = 1'b1;
        wif.commit = 1'b1;
        tick();
        wif.commit = 1'b0;
        check({tag, "_busy_wait"}, busy, 1);
        check({tag, "_no_early_done"}, commit_done, 0);
        tick();
        check({tag, "_done"}, commit_done, 1);
        check_grid({tag, "_grid"}, exp);
        tick();
        check({tag, "_done_one_pulse"}, commit_done, 0);
        check({tag, "_idle"}, busy, 0);
    endtask

    initial begin
        total         = 0;
        bad           = 0;
        rst           = 1'b1;
        vblank        = 1'b0;
        wif.wr_valid  = 1'b0;
        wif.wr_x      = '0;
        wif.wr_y      = '0;
        wif.wr_color  = '0;
        wif.clr_start = 1'b0;
        wif.clr_color = '0;
        wif.commit    = 1'b0;
        exp_g         = '0;

        // Reset state.
        repeat (2) @(posedge clk);
        #1;
        check("rst_busy", busy, 0);
        check("rst_done", commit_done, 0);
        check("rst_err", err_oob, 0);
        check("rst_wr_ready", wif.wr_ready, 1);
        check_grid("rst_grid", '0);
        @(negedge clk);
        rst = 1'b0;
        tick();

        // Write (5,3,green) -> index 197, bits [395:394]; publish after 100 cycles.
        wif.wr_valid = 1'b1;
        wif.wr_x     = 6'd5;
        wif.wr_y     = 6'd3;
        wif.wr_color = COLOR_GREEN;
        #1;
        check("wr_ready_idle", wif.wr_ready, 1);
        tick();
        wif.wr_valid = 1'b0;
        check_grid("flat_unchanged_after_write", '0);
        check("no_err_legal", err_oob, 0);
        wif.commit = 1'b1;
        #1;
        check("wr_ready_low_on_commit", wif.wr_ready, 0);
        tick();
        wif.commit = 1'b0;
        check("busy_commit_wait", busy, 1);
        cnt_a = 0;
        repeat (100) begin
            tick();
            if (commit_done) cnt_a++;
        end
        check("no_done_without_vblank", cnt_a, 0);
        check_grid("flat_held_in_wait", '0);
        vblank = 1'b1;
        tick();
        exp_g[395:394] = 2'b10;
        check("done_first_vblank", commit_done, 1);
        check_grid("flat_cell_5_3", exp_g);
        tick();
        check("done_single_pulse", commit_done, 0);
        check("busy_back_idle", busy, 0);
        vblank = 1'b0;

        // Corner cells and an out-of-range row.
        do_write(6'd0, 6'd0, COLOR_RED);
        do_write(6'd63, 6'd47, COLOR_BLUE);
        check("no_err_last_cell", err_oob, 0);
        do_write(6'd10, 6'd48, COLOR_BLUE);
        check("err_oob_pulse", err_oob, 1);
        tick();
        check("err_oob_one_cycle", err_oob, 0);
        exp_g[1:0]       = 2'b01;
        exp_g[6143:6142] = 2'b11;
        publish("pub_corners", exp_g);
        vblank = 1'b0;

        // Fill with red: busy exactly 3072 cycles; a second clr_start is ignored.
        wif.clr_color = COLOR_RED;
        wif.clr_start = 1'b1;
        #1;
        check("wr_ready_low_on_clr", wif.wr_ready, 0);
        tick();
        wif.clr_start = 1'b0;
        cnt_a = 0;
        for (int i = 0; i < GRID_CELLS; i++) begin
            if (!(busy === 1'b1 && wif.wr_ready === 1'b0)) cnt_a++;
            if (i == 10) begin
                wif.clr_start = 1'b1;
                wif.clr_color = COLOR_GREEN;
            end else begin
                wif.clr_start = 1'b0;
            end
            tick();
        end
        check("clear_busy_cycles", cnt_a, 0);
        check("clear_ends_3072", busy, 0);
        check("wr_ready_after_clear", wif.wr_ready, 1);
        exp_g = {GRID_CELLS{2'b01}};
        publish("pub_fill_red", exp_g);
        vblank = 1'b0;

        // Fill green with a commit at CLEAR cycle 100.
        wif.clr_color = COLOR_GREEN;
        wif.clr_start = 1'b1;
        tick();
        wif.clr_start = 1'b0;
        for (int i = 0; i < GRID_CELLS; i++) begin
            wif.commit = (i == 100);
            tick();
        end
        wif.commit = 1'b0;
        check("pending_to_commit_wait", busy, 1);
        check_grid("flat_held_after_clear", exp_g);
        repeat (5) tick();
        vblank = 1'b1;
        tick();
        exp_g = {GRID_CELLS{2'b10}};
        check("pending_done", commit_done, 1);
        check_grid("pub_fill_green", exp_g);
        cnt_a = 0;
        repeat (10) begin
            tick();
            if (commit_done) cnt_a++;
        end
        check("pending_done_once", cnt_a, 0);
        vblank = 1'b0;

        // clr_start and commit together: clear wins, commit is dropped.
        wif.clr_color = COLOR_BLUE;
        wif.clr_start = 1'b1;
        wif.commit    = 1'b1;
        tick();
        wif.clr_start = 1'b0;
        wif.commit    = 1'b0;
        vblank = 1'b1;
        cnt_a = 0;
        cnt_b = 0;
        repeat (4000) begin
            tick();
            if (commit_done) cnt_a++;
            if (grid_flat !== exp_g) cnt_b++;
        end
        check("dropped_commit_no_done", cnt_a, 0);
        check("dropped_commit_flat_cycles", cnt_b, 0);
        check("dropped_commit_idle", busy, 0);
        exp_g = {GRID_CELLS{2'b11}};
        publish("pub_fill_blue", exp_g);
        vblank = 1'b0;

        // Asynchronous reset at CLEAR cycle 1500.
        wif.clr_color = COLOR_RED;
        wif.clr_start = 1'b1;
        tick();
        wif.clr_start = 1'b0;
        repeat (1500) tick();
        #2;
        rst = 1'b1;
        #1;
        check("arst_clear_busy", busy, 0);
        check("arst_clear_done", commit_done, 0);
        check("arst_clear_err", err_oob, 0);
        check_grid("arst_clear_grid", '0);
        @(negedge clk);
        rst = 1'b0;
        tick();
        check("arst_clear_wr_ready", wif.wr_ready, 1);
        check("arst_clear_idle", busy, 0);
        exp_g = '0;
        publish("pub_after_clear_rst", exp_g);
        vblank = 1'b0;

        // Asynchronous reset during COMMIT_WAIT with vblank low.
        do_write(6'd1, 6'd1, COLOR_BLUE);
        wif.commit = 1'b1;
        tick();
        wif.commit = 1'b0;
        repeat (3) tick();
        check("wait_before_rst", busy, 1);
        #2;
        rst = 1'b1;
        #1;
        check("arst_wait_busy", busy, 0);
        check_grid("arst_wait_grid", '0);
        @(negedge clk);
        rst = 1'b0;
        tick();
        check("arst_wait_wr_ready", wif.wr_ready, 1);
        vblank = 1'b1;
        cnt_a = 0;
        repeat (5) begin
            tick();
            if (commit_done) cnt_a++;
        end
        check("arst_wait_no_done", cnt_a, 0);
        check_grid("arst_wait_grid_held", '0);
        publish("pub_after_wait_rst", exp_g);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
